// File: rtl/ex_div_sequencer_if.sv
// Handshake and data bundle between the EX stage and the divide sequencer.
// The pipeline side drives the request (master); the sequencer answers (slave).
interface ex_div_sequencer_if;
  logic        start;
  logic        flush;
  logic [3:0]  OpCode;
  logic [15:0] Dividend;
  logic [15:0] Divisor;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [15:0] result;
  logic [1:0]  div_zero;

  modport master (
    output start, flush, OpCode, Dividend, Divisor,
    input  stall, busy, result_valid, result, div_zero
  );

  modport slave (
    input  start, flush, OpCode, Dividend, Divisor,
    output stall, busy, result_valid, result, div_zero
  );
endinterface

// File: rtl/ex_div_sequencer.sv
// EX-stage divide sequencer: two independent 8-bit restoring dividers (hi/lo byte
// lanes) run in lockstep while the pipeline is stalled; the result leaves on a done pulse.
module ex_div_sequencer #(
  parameter logic [3:0] MOD_OPCODE = 4'd9,
  parameter int         ITERS      = 8
) (
  input logic               clk,
  input logic               rst,
  ex_div_sequencer_if.slave bus
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    dvdHi_q, dvdHi_d, dvdLo_q, dvdLo_d;
  logic [7:0]    dvsHi_q, dvsHi_d, dvsLo_q, dvsLo_d;
  logic [7:0]    remHi_q, remHi_d, remLo_q, remLo_d;
  logic          selMod_q, selMod_d;
  logic [15:0]   result_q, result_d;
  logic [1:0]    divZero_q, divZero_d;
  logic          busy_q;
  logic [8:0]    stepHi, stepLo;
  logic          stall;

  // One restoring step; returns {quotient bit, new partial remainder}.
  // The dividend register doubles as the quotient register as bits shift in.
  function automatic logic [8:0] restoringStep(input logic [7:0] rem,
                                               input logic       msb,
                                               input logic [7:0] dvs);
    logic [8:0] shifted;
    logic [7:0] diff;
    shifted = {rem, msb};
    diff    = shifted[7:0] - dvs;
    if (shifted >= {1'b0, dvs})
      return {1'b1, diff};
    else
      return {1'b0, shifted[7:0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dvdHi_d   = dvdHi_q;
    dvdLo_d   = dvdLo_q;
    dvsHi_d   = dvsHi_q;
    dvsLo_d   = dvsLo_q;
    remHi_d   = remHi_q;
    remLo_d   = remLo_q;
    selMod_d  = selMod_q;
    result_d  = result_q;
    divZero_d = divZero_q;
    stepHi    = restoringStep(remHi_q, dvdHi_q[7], dvsHi_q);
    stepLo    = restoringStep(remLo_q, dvdLo_q[7], dvsLo_q);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          dvdHi_d  = bus.Dividend[15:8];
          dvdLo_d  = bus.Dividend[7:0];
          dvsHi_d  = bus.Divisor[15:8];
          dvsLo_d  = bus.Divisor[7:0];
          selMod_d = (bus.OpCode == MOD_OPCODE);
          remHi_d  = '0;
          remLo_d  = '0;
          count_d  = '0;
          state_d  = ITER;
        end
      end
      ITER: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          remHi_d = stepHi[7:0];
          remLo_d = stepLo[7:0];
          dvdHi_d = {dvdHi_q[6:0], stepHi[8]};
          dvdLo_d = {dvdLo_q[6:0], stepLo[8]};
          count_d = count_q + 1'b1;
          // Capture the answer on the final step so it is already valid in DONE.
          if (count_q == LAST) begin
            state_d   = DONE;
            result_d  = selMod_q ? {stepHi[7:0], stepLo[7:0]} : {dvdHi_d, dvdLo_d};
            divZero_d = {dvsHi_q == 8'd0, dvsLo_q == 8'd0};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Released in DONE so the pipeline advances in the cycle it samples the result.
    stall = ((state_q == IDLE) && bus.start && !bus.flush) || (state_q == ITER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dvdHi_q   <= '0;
      dvdLo_q   <= '0;
      dvsHi_q   <= '0;
      dvsLo_q   <= '0;
      remHi_q   <= '0;
      remLo_q   <= '0;
      selMod_q  <= 1'b0;
      result_q  <= '0;
      divZero_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dvdHi_q   <= dvdHi_d;
      dvdLo_q   <= dvdLo_d;
      dvsHi_q   <= dvsHi_d;
      dvsLo_q   <= dvsLo_d;
      remHi_q   <= remHi_d;
      remLo_q   <= remLo_d;
      selMod_q  <= selMod_d;
      result_q  <= result_d;
      divZero_q <= divZero_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.stall        = stall;
  assign bus.busy         = busy_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.div_zero     = divZero_q;

endmodule
